// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl: parses SOF / length / payload frames from a UART byte strobe into a 4-entry FIFO.
// Define UART_RX_FRAME_CHKSUM_EN to require a trailing XOR checksum byte (len ^ payload).
module uart_rx_frame_ctrl #(
  parameter int unsigned MAX_LEN      = 16,
  parameter int unsigned TIMEOUT_CLKS = 2048,
  parameter logic [7:0]  SOF          = 8'hA5
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rx_done,
  input  logic [7:0] rx_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_last,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic       busy
);

  localparam int unsigned   CW        = $clog2(TIMEOUT_CLKS);
  localparam logic [CW-1:0] TMO_MAX   = CW'(TIMEOUT_CLKS - 1);
  localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [1:0]    ERR_LEN   = 2'b00;
  localparam logic [1:0]    ERR_TMO   = 2'b01;
  localparam logic [1:0]    ERR_OVF   = 2'b10;
`ifdef UART_RX_FRAME_CHKSUM_EN
  localparam logic [1:0]    ERR_CHK   = 2'b11;

  typedef enum logic [1:0] {ST_IDLE, ST_LEN, ST_PAYLOAD, ST_CHK} state_t;
  logic [7:0] chk;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_LEN, ST_PAYLOAD} state_t;
`endif

  state_t        state;
  logic [7:0]    len;
  logic [7:0]    rcvd;
  logic [CW-1:0] tmo_cnt;
  logic [8:0]    mem [4];
  logic [1:0]    wr_ptr;
  logic [1:0]    rd_ptr;
  logic [2:0]    count;
  logic          fifo_full;
  logic          pop;
  logic          push;
  logic          tmo_hit;
  logic          pay_last;

  assign fifo_full = (count == 3'd4);
  assign pop       = out_valid && out_ready;
  assign tmo_hit   = (state != ST_IDLE) && !rx_done && (tmo_cnt == TMO_MAX);
  // Remaining count is derived as len - rcvd rather than kept as a separate down-counter.
  assign pay_last  = ((len - rcvd) == 8'd1);
  assign push      = rx_done && (state == ST_PAYLOAD) && (!fifo_full || pop);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      len       <= '0;
      rcvd      <= '0;
      tmo_cnt   <= '0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      err_code  <= '0;
`ifdef UART_RX_FRAME_CHKSUM_EN
      chk       <= '0;
`endif
    end else begin
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      err_code  <= '0;
      tmo_cnt   <= (state == ST_IDLE || rx_done) ? '0 : tmo_cnt + 1'b1;
      if (tmo_hit) begin
        state     <= ST_IDLE;
        busy      <= 1'b0;
        frame_err <= 1'b1;
        err_code  <= ERR_TMO;
      end else if (rx_done) begin
        case (state)
          ST_IDLE: begin
            if (rx_data == SOF) begin
              state <= ST_LEN;
              busy  <= 1'b1;
            end
          end
          ST_LEN: begin
            if (rx_data == 8'd0 || rx_data > MAX_LEN_B) begin
              state     <= ST_IDLE;
              busy      <= 1'b0;
              frame_err <= 1'b1;
              err_code  <= ERR_LEN;
            end else begin
              len   <= rx_data;
              rcvd  <= '0;
              state <= ST_PAYLOAD;
`ifdef UART_RX_FRAME_CHKSUM_EN
              chk   <= rx_data;
`endif
            end
          end
          ST_PAYLOAD: begin
            if (!push) begin
              state     <= ST_IDLE;
              busy      <= 1'b0;
              frame_err <= 1'b1;
              err_code  <= ERR_OVF;
            end else begin
              rcvd <= rcvd + 1'b1;
`ifdef UART_RX_FRAME_CHKSUM_EN
              chk  <= chk ^ rx_data;
              if (pay_last) state <= ST_CHK;
`else
              if (pay_last) begin
                state    <= ST_IDLE;
                busy     <= 1'b0;
                frame_ok <= 1'b1;
              end
`endif
            end
          end
`ifdef UART_RX_FRAME_CHKSUM_EN
          ST_CHK: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            if (rx_data == chk) begin
              frame_ok <= 1'b1;
            end else begin
              frame_err <= 1'b1;
              err_code  <= ERR_CHK;
            end
          end
`endif
          default: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  // Payload FIFO is not flushed on abort; only reset clears it.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      mem    <= '{default: '0};
    end else begin
      if (push) begin
        mem[wr_ptr] <= {pay_last, rx_data};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign out_valid           = (count != 3'd0);
  assign {out_last, out_data} = mem[rd_ptr];

endmodule
